// File: rtl/vram_fill_arbiter.sv
// vram_fill_arbiter: CPU/rect-fill VRAM write arbiter, CPU wins; FILL_STALL_CNT_EN builds the stall counter
module vram_fill_arbiter #(
   parameter int H_RES   = 160,
   parameter int V_RES   = 120,
   parameter int ADDR_W  = 16,
   parameter int COLOR_W = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cpu_we_i,
   input  logic [ADDR_W-1:0]  cpu_addr_i,
   input  logic [COLOR_W-1:0] cpu_data_i,
   input  logic               fill_start_i,
   input  logic [7:0]         fill_x_i,
   input  logic [7:0]         fill_y_i,
   input  logic [7:0]         fill_w_i,
   input  logic [7:0]         fill_h_i,
   input  logic [COLOR_W-1:0] fill_color_i,
   input  logic               fill_abort_i,
   output logic               vram_we_o,
   output logic [ADDR_W-1:0]  vram_addr_o,
   output logic [COLOR_W-1:0] vram_data_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               clip_o,
   output logic [15:0]        stall_cnt_o
);
   typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
   localparam logic [8:0]        H9 = 9'(H_RES);
   localparam logic [8:0]        V9 = 9'(V_RES);
   localparam logic [ADDR_W-1:0] HA = ADDR_W'(H_RES);
   state_t             state_q, state_d;
   logic [7:0]         x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
   logic [COLOR_W-1:0] color_q, color_d, vram_data_q, vram_data_d;
   logic [ADDR_W-1:0]  base_q, base_d, vram_addr_q, vram_addr_d;
   logic               vram_we_q, vram_we_d, clip_q, clip_d;
   logic               in_rej, in_clip, reject, fill_issue, last_col;
   logic [8:0]         room_x, room_y;
   // clip flag decided from the start inputs so it never glitches low on a clipped start
   assign in_rej  = ({1'b0, fill_x_i} >= H9) || ({1'b0, fill_y_i} >= V9) || (fill_w_i == 8'd0) || (fill_h_i == 8'd0);
   assign in_clip = in_rej || ({1'b0, fill_x_i} + {1'b0, fill_w_i} > H9) || ({1'b0, fill_y_i} + {1'b0, fill_h_i} > V9);
   assign reject  = ({1'b0, x_q} >= H9) || ({1'b0, y_q} >= V9) || (w_q == 8'd0) || (h_q == 8'd0);
   assign room_x  = H9 - {1'b0, x_q};
   assign room_y  = V9 - {1'b0, y_q};
   assign fill_issue = (state_q == FILL) && !cpu_we_i && !fill_abort_i;
   assign last_col   = col_q == w_q - 8'd1;
   // after SETUP, w_q/h_q hold the clipped extents ew/eh
   // next-state and fill-walker update; the walker freezes on CPU cycles
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      w_d     = w_q;
      h_d     = h_q;
      col_d   = col_q;
      row_d   = row_q;
      color_d = color_q;
      base_d  = base_q;
      clip_d  = clip_q;
      case (state_q)
         IDLE: if (fill_start_i) begin
            x_d     = fill_x_i;
            y_d     = fill_y_i;
            w_d     = fill_w_i;
            h_d     = fill_h_i;
            color_d = fill_color_i;
            clip_d  = in_clip;
            state_d = SETUP;
         end
         SETUP: begin
            w_d     = ({1'b0, w_q} > room_x) ? room_x[7:0] : w_q;
            h_d     = ({1'b0, h_q} > room_y) ? room_y[7:0] : h_q;
            base_d  = ADDR_W'(y_q) * HA + ADDR_W'(x_q);
            col_d   = '0;
            row_d   = '0;
            state_d = fill_abort_i ? IDLE : reject ? DONE : FILL;
         end
         FILL: if (fill_abort_i) state_d = IDLE;
         else if (!cpu_we_i) begin
            col_d = last_col ? 8'd0 : col_q + 8'd1;
            if (last_col) begin
               row_d  = row_q + 8'd1;
               base_d = base_q + HA;
               if (row_q == h_q - 8'd1) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // VRAM port mux: CPU first, then fill pixel, else hold address/data
   assign vram_we_d   = cpu_we_i || fill_issue;
   assign vram_addr_d = cpu_we_i ? cpu_addr_i : fill_issue ? base_q + ADDR_W'(col_q) : vram_addr_q;
   assign vram_data_d = cpu_we_i ? cpu_data_i : fill_issue ? color_q : vram_data_q;
   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         w_q         <= '0;
         h_q         <= '0;
         col_q       <= '0;
         row_q       <= '0;
         color_q     <= '0;
         base_q      <= '0;
         clip_q      <= 1'b0;
         vram_we_q   <= 1'b0;
         vram_addr_q <= '0;
         vram_data_q <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         w_q         <= w_d;
         h_q         <= h_d;
         col_q       <= col_d;
         row_q       <= row_d;
         color_q     <= color_d;
         base_q      <= base_d;
         clip_q      <= clip_d;
         vram_we_q   <= vram_we_d;
         vram_addr_q <= vram_addr_d;
         vram_data_q <= vram_data_d;
      end
   end
   assign vram_we_o   = vram_we_q;
   assign vram_addr_o = vram_addr_q;
   assign vram_data_o = vram_data_q;
   assign busy_o      = state_q != IDLE;
   assign done_o      = state_q == DONE;
   assign clip_o      = clip_q;
`ifdef FILL_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;
   assign stall_d = (state_q == IDLE && fill_start_i) ? 16'd0 :
                    (state_q == FILL && cpu_we_i && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
   // saturating count of fill cycles lost to CPU writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else stall_q <= stall_d;
   end
   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = 16'd0;
`endif
endmodule

// File: tb/tb_vram_fill_arbiter.sv
// tb_vram_fill_arbiter: table vectors, corner sequences and randomized run against a queue-based model
module tb_vram_fill_arbiter;
   localparam int H = 160;
   localparam int V = 120;
   logic        clk = 0, rst_n = 0;
   logic        cpu_we = 0, fill_start = 0, fill_abort = 0;
   logic [15:0] cpu_addr = 0;
   logic [11:0] cpu_data = 0, fill_color = 0;
   logic [7:0]  fill_x = 0, fill_y = 0, fill_w = 0, fill_h = 0;
   logic        vram_we, busy, done, clip;
   logic [15:0] vram_addr, stall_cnt;
   logic [11:0] vram_data;
   int n_cmp = 0, n_bad = 0;

   typedef struct {
      logic [7:0]  x, y, w, h;
      logic [11:0] color;
      int          n;
      logic        clip;
      int          first, last, lat;
   } vec_t;
   vec_t vt[10];

   vram_fill_arbiter dut (
      .clk(clk), .rst_n(rst_n), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data),
      .fill_start_i(fill_start), .fill_x_i(fill_x), .fill_y_i(fill_y), .fill_w_i(fill_w), .fill_h_i(fill_h),
      .fill_color_i(fill_color), .fill_abort_i(fill_abort), .vram_we_o(vram_we), .vram_addr_o(vram_addr),
      .vram_data_o(vram_data), .busy_o(busy), .done_o(done), .clip_o(clip), .stall_cnt_o(stall_cnt)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " we"}, {31'd0, vram_we}, 0);
      chk({tag, " addr"}, {16'd0, vram_addr}, 0);
      chk({tag, " data"}, {20'd0, vram_data}, 0);
      chk({tag, " busy"}, {31'd0, busy}, 0);
      chk({tag, " done"}, {31'd0, done}, 0);
      chk({tag, " clip"}, {31'd0, clip}, 0);
      chk({tag, " stall"}, {16'd0, stall_cnt}, 0);
   endtask

   // runs one fill; optional CPU burst on steps [cpu_at, cpu_at+cpu_len) and a stray start at restart_at
   task automatic run_fill(input vec_t v, input int cpu_at, input int cpu_len, input int restart_at, input string tag);
      int k, nw, first, last;
      bit dn, cw;
      fill_x = v.x; fill_y = v.y; fill_w = v.w; fill_h = v.h; fill_color = v.color;
      fill_start = 1;
      k = 0; nw = 0; first = -1; last = -1; dn = 0;
      while (!dn && k < 30000) begin
         k++;
         cw = (k >= cpu_at) && (k < cpu_at + cpu_len);
         cpu_we = cw; cpu_addr = 16'h0010; cpu_data = 12'h0AB;
         if (k == restart_at) begin
            fill_start = 1; fill_x = 8'd0; fill_y = 8'd0; fill_w = 8'd1; fill_h = 8'd1;
         end
         step();
         fill_start = 0; cpu_we = 0;
         if (cw) begin
            chk({tag, " cpu we"}, {31'd0, vram_we}, 1);
            chk({tag, " cpu addr"}, {16'd0, vram_addr}, 32'h10);
            chk({tag, " cpu data"}, {20'd0, vram_data}, 32'h0AB);
         end else if (vram_we) begin
            nw++;
            if (first < 0) first = int'(vram_addr);
            last = int'(vram_addr);
            chk({tag, " fill data"}, {20'd0, vram_data}, {20'd0, v.color});
         end
         dn = done;
      end
      chk({tag, " done seen"}, {31'd0, dn}, 1);
      chk({tag, " writes"}, nw, v.n);
      chk({tag, " clip"}, {31'd0, clip}, {31'd0, v.clip});
      chk({tag, " latency"}, k, v.lat);
      if (v.n > 0) begin
         chk({tag, " first"}, first, v.first);
         chk({tag, " last"}, last, v.last);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         chk({tag, " idle busy"}, {31'd0, busy}, 0);
         chk({tag, " idle done"}, {31'd0, done}, 0);
      end
   endtask

   // reference model: a fill is a queue of pixel addresses built from the clipping rules
   localparam int P_IDLE = 0, P_SETUP = 1, P_WRITE = 2, P_DONE = 3;
   int          ph;
   int          q[$];
   logic [11:0] m_color, m_data;
   logic [15:0] m_addr, m_stall;
   logic        m_we, m_clip;

   task automatic model_start(input int x, input int y, input int w, input int h);
      int ew, eh;
      q.delete();
      if (x >= H || y >= V || w == 0 || h == 0) m_clip = 1;
      else begin
         ew = (w < H - x) ? w : H - x;
         eh = (h < V - y) ? h : V - y;
         m_clip = (ew < w) || (eh < h);
         for (int r = 0; r < eh; r++)
            for (int c = 0; c < ew; c++) q.push_back((y + r) * H + x + c);
      end
   endtask

   task automatic model_cycle();
      m_we = 0;
      if (cpu_we) begin
         m_we = 1; m_addr = cpu_addr; m_data = cpu_data;
      end
      case (ph)
         P_IDLE: if (fill_start) begin
            model_start(int'(fill_x), int'(fill_y), int'(fill_w), int'(fill_h));
            m_color = fill_color; m_stall = 0; ph = P_SETUP;
         end
         P_SETUP: begin
            if (fill_abort) q.delete();
            ph = fill_abort ? P_IDLE : (q.size() == 0) ? P_DONE : P_WRITE;
         end
         P_WRITE: begin
            if (cpu_we && m_stall != 16'hFFFF) m_stall++;
            if (fill_abort) begin
               q.delete(); ph = P_IDLE;
            end else if (!cpu_we) begin
               m_we = 1; m_addr = 16'(q.pop_front()); m_data = m_color;
               if (q.size() == 0) ph = P_DONE;
            end
         end
         default: ph = P_IDLE;
      endcase
   endtask

   initial begin
      int nw, nd;
      logic [15:0] exp_stall;
      vt[0] = '{8'd2,   8'd3,   8'd4,   8'd2,  12'hF00, 8,   1'b0, 482,   645,   10};
      vt[1] = '{8'd158, 8'd118, 8'd10,  8'd10, 12'h0F0, 4,   1'b1, 19038, 19199, 6};
      vt[2] = '{8'd200, 8'd0,   8'd5,   8'd5,  12'h00F, 0,   1'b1, 0,     0,     2};
      vt[3] = '{8'd0,   8'd0,   8'd1,   8'd1,  12'h123, 1,   1'b0, 0,     0,     3};
      vt[4] = '{8'd10,  8'd10,  8'd0,   8'd5,  12'h456, 0,   1'b1, 0,     0,     2};
      vt[5] = '{8'd159, 8'd119, 8'd1,   8'd1,  12'h789, 1,   1'b0, 19199, 19199, 3};
      vt[6] = '{8'd0,   8'd119, 8'd160, 8'd1,  12'hABC, 160, 1'b0, 19040, 19199, 162};
      vt[7] = '{8'd150, 8'd0,   8'd20,  8'd3,  12'hDEF, 30,  1'b1, 150,   479,   32};
      vt[8] = '{8'd5,   8'd120, 8'd3,   8'd3,  12'h111, 0,   1'b1, 0,     0,     2};
      vt[9] = '{8'd0,   8'd100, 8'd4,   8'd30, 12'h222, 80,  1'b1, 16000, 19043, 82};

      #5;
      check_all_zero("reset");
      step();
      rst_n = 1;
      step();

      foreach (vt[i]) run_fill(vt[i], 0, 0, 0, $sformatf("vec%0d", i));

      // CPU burst steals three fill slots and pushes done out by three cycles
      run_fill('{8'd2, 8'd3, 8'd4, 8'd2, 12'hF00, 8, 1'b0, 482, 645, 13}, 4, 3, 0, "cpu_prio");
`ifdef FILL_STALL_CNT_EN
      exp_stall = 16'd3;
`else
      exp_stall = 16'd0;
`endif
      chk("cpu_prio stall", {16'd0, stall_cnt}, {16'd0, exp_stall});

      // a start while busy is neither taken nor queued
      run_fill('{8'd2, 8'd3, 8'd4, 8'd2, 12'h0F0, 8, 1'b0, 482, 645, 10}, 0, 0, 5, "busy_start");

      // abort after five fill writes
      fill_x = 0; fill_y = 0; fill_w = 16; fill_h = 16; fill_color = 12'h321; fill_start = 1;
      step();
      fill_start = 0;
      step();
      nw = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         nw += int'(vram_we);
      end
      chk("abort pre writes", nw, 5);
      fill_abort = 1;
      step();
      fill_abort = 0;
      chk("abort we", {31'd0, vram_we}, 0);
      chk("abort busy", {31'd0, busy}, 0);
      nw = 0; nd = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         nw += int'(vram_we);
         nd += int'(done);
      end
      chk("abort after writes", nw, 0);
      chk("abort after done", nd, 0);
      run_fill(vt[3], 0, 0, 0, "post_abort");

      // asynchronous reset mid-fill
      fill_x = 0; fill_y = 0; fill_w = 8; fill_h = 8; fill_color = 12'hABC; fill_start = 1;
      step();
      fill_start = 0;
      for (int i = 0; i < 6; i++) step();
      chk("pre reset busy", {31'd0, busy}, 1);
      #3 rst_n = 0;
      #1 check_all_zero("async reset");
      step();
      step();
      rst_n = 1;
      nw = 0; nd = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         nw += int'(vram_we);
         nd += int'(done) + int'(busy);
      end
      chk("post reset writes", nw, 0);
      chk("post reset busy/done", nd, 0);

      // randomized traffic against the model
      rst_n = 0;
      step();
      rst_n = 1;
      ph = P_IDLE; q.delete(); m_we = 0; m_addr = 0; m_data = 0; m_color = 0; m_stall = 0; m_clip = 0;
      for (int i = 0; i < 4000; i++) begin
         cpu_we = ($urandom % 4) == 0;
         cpu_addr = 16'($urandom);
         cpu_data = 12'($urandom);
         fill_start = ($urandom % 6) == 0;
         fill_abort = ($urandom % 64) == 0;
         fill_x = ($urandom % 2) ? 8'($urandom_range(150, 165)) : 8'($urandom_range(0, 175));
         fill_y = ($urandom % 2) ? 8'($urandom_range(112, 125)) : 8'($urandom_range(0, 130));
         fill_w = 8'($urandom_range(0, 12));
         fill_h = 8'($urandom_range(0, 10));
         fill_color = 12'($urandom);
         model_cycle();
`ifdef FILL_STALL_CNT_EN
         exp_stall = m_stall;
`else
         exp_stall = 16'd0;
`endif
         step();
         chk("rnd we", {31'd0, vram_we}, {31'd0, m_we});
         chk("rnd addr", {16'd0, vram_addr}, {16'd0, m_addr});
         chk("rnd data", {20'd0, vram_data}, {20'd0, m_data});
         chk("rnd busy", {31'd0, busy}, {31'd0, ph != P_IDLE});
         chk("rnd done", {31'd0, done}, {31'd0, ph == P_DONE});
         chk("rnd clip", {31'd0, clip}, {31'd0, m_clip});
         chk("rnd stall", {16'd0, stall_cnt}, {16'd0, exp_stall});
      end
      cpu_we = 0; fill_start = 0; fill_abort = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
